// File: rtl/dot_pkg.sv
// Shared types and constants for the dot-product sequencer.
package dot_pkg;
    localparam int NIBBLES = 4;
    localparam int SUM_W   = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_LOAD_I,
        ST_SETTLE,
        ST_SAMPLE,
        ST_RESP
    } state_t;

    function automatic logic [3:0] nib_sel(input logic [15:0] v, input logic [1:0] b);
        return v[b*4 +: 4];
    endfunction
endpackage

// File: rtl/dot_max_tracker.sv
// Running maximum / argmax over sampled dot products; strict compare keeps the earlier index on ties.
module dot_max_tracker
    import dot_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [SUM_W-1:0]  i_sum,
    input  logic [IDX_W-1:0]  i_idx,
    output logic [SUM_W-1:0]  o_max,
    output logic [IDX_W-1:0]  o_argmax,
    output logic              o_new_max
);
    logic [SUM_W-1:0] r_max;
    logic [IDX_W-1:0] r_argmax;
    logic             r_new_max;
    logic             w_upd;

    assign w_upd = i_clr || (i_sum > r_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_max     <= '0;
            r_argmax  <= '0;
            r_new_max <= 1'b0;
        end else if (i_en) begin
            r_new_max <= w_upd;
            if (w_upd) begin
                r_max    <= i_sum;
                r_argmax <= i_idx;
            end
        end
    end

    assign o_max     = r_max;
    assign o_argmax  = r_argmax;
    assign o_new_max = r_new_max;
endmodule

// File: rtl/dot_seq_ctrl.sv
// Sequences one command's weights then inputs into the dot-product datapath, samples the sum
// and presents it with running max/argmax over a valid/ready result port.
module dot_seq_ctrl
    import dot_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [15:0]       cmd_weights,
    input  logic [15:0]       cmd_inputs,
    input  logic              cmd_clear_max,
    output logic [3:0]        dp_nibble,
    output logic              dp_sel_w,
    output logic              dp_shift,
    input  logic [SUM_W-1:0]  dp_sum,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [SUM_W-1:0]  res_sum,
    output logic [SUM_W-1:0]  res_max,
    output logic [IDX_W-1:0]  res_idx,
    output logic [IDX_W-1:0]  res_argmax,
    output logic              res_new_max
);
    state_t           r_state, w_next;
    logic [1:0]       r_beat;
    logic [15:0]      r_w, r_i;
    logic             r_clr;
    logic [IDX_W-1:0] r_idx_cnt, r_res_idx, w_cur_idx;
    logic [SUM_W-1:0] r_res_sum;
    logic             w_sample;

    assign w_sample  = (r_state == ST_SAMPLE);
    // A cleared command restarts numbering so it becomes index 0.
    assign w_cur_idx = r_clr ? '0 : r_idx_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        dp_shift  = 1'b0;
        dp_sel_w  = 1'b0;
        dp_nibble = 4'd0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_next = ST_LOAD_W;
            end
            ST_LOAD_W: begin
                dp_shift  = 1'b1;
                dp_sel_w  = 1'b1;
                dp_nibble = nib_sel(r_w, r_beat);
                if (r_beat == 2'd3) w_next = ST_LOAD_I;
            end
            ST_LOAD_I: begin
                dp_shift  = 1'b1;
                dp_nibble = nib_sel(r_i, r_beat);
                if (r_beat == 2'd3) w_next = ST_SETTLE;
            end
            ST_SETTLE: w_next = ST_SAMPLE;
            ST_SAMPLE: w_next = ST_RESP;
            ST_RESP: begin
                res_valid = 1'b1;
                if (res_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat    <= '0;
            r_w       <= '0;
            r_i       <= '0;
            r_clr     <= 1'b0;
            r_idx_cnt <= '0;
            r_res_idx <= '0;
            r_res_sum <= '0;
        end else begin
            // Beat wraps 3->0 on the LOAD_W -> LOAD_I transition.
            if (r_state == ST_LOAD_W || r_state == ST_LOAD_I) r_beat <= r_beat + 2'd1;
            else                                                r_beat <= '0;
            if (r_state == ST_IDLE && cmd_valid) begin
                r_w   <= cmd_weights;
                r_i   <= cmd_inputs;
                r_clr <= cmd_clear_max;
            end
            if (w_sample) begin
                r_res_sum <= dp_sum;
                r_res_idx <= w_cur_idx;
                r_idx_cnt <= (w_cur_idx == '1) ? w_cur_idx : w_cur_idx + IDX_W'(1);
            end
        end
    end

    dot_max_tracker #(.IDX_W(IDX_W)) u_max (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_sample),
        .i_clr     (r_clr),
        .i_sum     (dp_sum),
        .i_idx     (w_cur_idx),
        .o_max     (res_max),
        .o_argmax  (res_argmax),
        .o_new_max (res_new_max)
    );

    assign res_sum = r_res_sum;
    assign res_idx = r_res_idx;
endmodule

// File: tb/tb_dot_seq_ctrl.sv
// Directed bench for dot_seq_ctrl with a behavioural shift-register dot-product datapath.
module tb_dot_seq_ctrl;
    import dot_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready, cmd_clear_max;
    logic [15:0]      cmd_weights, cmd_inputs;
    logic [3:0]       dp_nibble;
    logic             dp_sel_w, dp_shift;
    logic [SUM_W-1:0] dp_sum;
    logic             res_valid, res_ready, res_new_max;
    logic [SUM_W-1:0] res_sum, res_max;
    logic [3:0]       res_idx, res_argmax;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dot_seq_ctrl #(.IDX_W(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_weights(cmd_weights), .cmd_inputs(cmd_inputs), .cmd_clear_max(cmd_clear_max),
        .dp_nibble(dp_nibble), .dp_sel_w(dp_sel_w), .dp_shift(dp_shift), .dp_sum(dp_sum),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_max(res_max),
        .res_idx(res_idx), .res_argmax(res_argmax), .res_new_max(res_new_max)
    );

    // Datapath model: both registers shift in from the top, never reset.
    logic [15:0] m_w = '0;
    logic [15:0] m_i = '0;
    always_ff @(posedge clk) begin
        if (dp_shift) begin
            if (dp_sel_w) m_w <= {dp_nibble, m_w[15:4]};
            else          m_i <= {dp_nibble, m_i[15:4]};
        end
    end
    always_comb begin
        dp_sum = '0;
        for (int k = 0; k < 4; k++) dp_sum = dp_sum + 10'(m_w[k*4 +: 4]) * 10'(m_i[k*4 +: 4]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a command; returns positioned at cycle 1 after the acceptance edge.
    task automatic accept(input logic [15:0] w, input logic [15:0] i, input logic clr);
        int n = 0;
        while (!cmd_ready && n < 40) begin tick(); n++; end
        if (!cmd_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout cmd_ready=%0b after %0d cycles", cmd_ready, n);
        end
        cmd_weights = w; cmd_inputs = i; cmd_clear_max = clr; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(output int lat);
        lat = 1;
        while (!res_valid && lat < 40) begin tick(); lat++; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || dp_shift !== 1'b0) begin failures++;
            $display("FAIL reset_ctrl got rdy=%0b vld=%0b sh=%0b exp 1 0 0", cmd_ready, res_valid, dp_shift); end
        checks++; if (res_sum !== 10'd0 || res_max !== 10'd0 || res_idx !== 4'd0 || res_argmax !== 4'd0 || res_new_max !== 1'b0) begin failures++;
            $display("FAIL reset_res got sum=%0d max=%0d idx=%0d am=%0d nm=%0b exp all 0", res_sum, res_max, res_idx, res_argmax, res_new_max); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_order();
        logic [3:0] nib;
        logic       sel;
        accept(16'h4321, 16'h8765, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            nib = 4'(c);
            sel = (c <= 4);
            checks++; if (dp_shift !== 1'b1 || dp_sel_w !== sel || dp_nibble !== nib) begin failures++;
                $display("FAIL load_cyc%0d got sh=%0b sel=%0b nib=%0d exp 1 %0b %0d", c, dp_shift, dp_sel_w, dp_nibble, sel, nib); end
            tick();
        end
        for (int c = 9; c <= 10; c++) begin
            checks++; if (dp_shift !== 1'b0 || dp_nibble !== 4'd0 || res_valid !== 1'b0) begin failures++;
                $display("FAIL idle_cyc%0d got sh=%0b nib=%0d vld=%0b exp 0 0 0", c, dp_shift, dp_nibble, res_valid); end
            tick();
        end
        checks++; if (res_valid !== 1'b1 || res_sum !== 10'd70) begin failures++;
            $display("FAIL load_result got vld=%0b sum=%0d exp 1 70", res_valid, res_sum); end
        tick();
    endtask

    task automatic test_basic();
        int lat;
        accept(16'h1111, 16'h2222, 1'b1);
        wait_res(lat);
        checks++; if (lat != 11 || res_valid !== 1'b1) begin failures++;
            $display("FAIL basic_latency got=%0d vld=%0b exp 11 1", lat, res_valid); end
        checks++; if (res_sum !== 10'd8 || res_max !== 10'd8 || res_argmax !== 4'd0 || res_new_max !== 1'b1 || res_idx !== 4'd0) begin failures++;
            $display("FAIL basic_res got sum=%0d max=%0d am=%0d nm=%0b idx=%0d exp 8 8 0 1 0", res_sum, res_max, res_argmax, res_new_max, res_idx); end
        tick();
        checks++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin failures++;
            $display("FAIL basic_return got rdy=%0b vld=%0b exp 1 0", cmd_ready, res_valid); end
    endtask

    task automatic test_max_track();
        int lat;
        accept(16'hFFFF, 16'hFFFF, 1'b0);
        wait_res(lat);
        checks++; if (res_valid !== 1'b1 || res_sum !== 10'd900 || res_idx !== 4'd1 || res_new_max !== 1'b1 || res_max !== 10'd900 || res_argmax !== 4'd1) begin failures++;
            $display("FAIL max_up got sum=%0d idx=%0d nm=%0b max=%0d am=%0d exp 900 1 1 900 1", res_sum, res_idx, res_new_max, res_max, res_argmax); end
        tick();
        accept(16'h1111, 16'h2222, 1'b0);
        wait_res(lat);
        checks++; if (res_valid !== 1'b1 || res_sum !== 10'd8 || res_idx !== 4'd2 || res_new_max !== 1'b0 || res_max !== 10'd900 || res_argmax !== 4'd1) begin failures++;
            $display("FAIL max_keep got sum=%0d idx=%0d nm=%0b max=%0d am=%0d exp 8 2 0 900 1", res_sum, res_idx, res_new_max, res_max, res_argmax); end
        tick();
    endtask

    task automatic test_tie();
        int lat;
        accept(16'hFFFF, 16'hFFFF, 1'b0);
        wait_res(lat);
        checks++; if (res_valid !== 1'b1 || res_sum !== 10'd900 || res_idx !== 4'd3 || res_new_max !== 1'b0 || res_max !== 10'd900 || res_argmax !== 4'd1) begin failures++;
            $display("FAIL tie got sum=%0d idx=%0d nm=%0b max=%0d am=%0d exp 900 3 0 900 1", res_sum, res_idx, res_new_max, res_max, res_argmax); end
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [SUM_W-1:0] s0, m0;
        res_ready = 1'b0;
        accept(16'h1111, 16'h2222, 1'b0);
        wait_res(lat);
        s0 = res_sum; m0 = res_max;
        checks++; if (res_valid !== 1'b1 || s0 !== 10'd8 || res_idx !== 4'd4 || m0 !== 10'd900 || res_argmax !== 4'd1 || res_new_max !== 1'b0) begin failures++;
            $display("FAIL bp_res got sum=%0d idx=%0d max=%0d am=%0d nm=%0b exp 8 4 900 1 0", s0, res_idx, m0, res_argmax, res_new_max); end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (res_valid !== 1'b1 || cmd_ready !== 1'b0 || res_sum !== 10'd8 || res_max !== 10'd900 || res_idx !== 4'd4 || res_argmax !== 4'd1 || res_new_max !== 1'b0) begin failures++;
                $display("FAIL bp_hold%0d got vld=%0b rdy=%0b sum=%0d max=%0d idx=%0d exp 1 0 8 900 4", c, res_valid, cmd_ready, res_sum, res_max, res_idx); end
        end
        res_ready = 1'b1;
        tick();
        checks++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin failures++;
            $display("FAIL bp_release got rdy=%0b vld=%0b exp 1 0", cmd_ready, res_valid); end
    endtask

    task automatic test_mid_reset();
        int lat;
        accept(16'h4321, 16'h8765, 1'b0);
        repeat (6) tick();
        checks++; if (dp_shift !== 1'b1 || dp_sel_w !== 1'b0 || dp_nibble !== 4'd7) begin failures++;
            $display("FAIL mr_beat2 got sh=%0b sel=%0b nib=%0d exp 1 0 7", dp_shift, dp_sel_w, dp_nibble); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (cmd_ready !== 1'b1 || dp_shift !== 1'b0 || res_valid !== 1'b0 || dp_nibble !== 4'd0) begin failures++;
            $display("FAIL mr_ctrl got rdy=%0b sh=%0b vld=%0b nib=%0d exp 1 0 0 0", cmd_ready, dp_shift, res_valid, dp_nibble); end
        checks++; if (res_sum !== 10'd0 || res_max !== 10'd0 || res_idx !== 4'd0 || res_argmax !== 4'd0 || res_new_max !== 1'b0) begin failures++;
            $display("FAIL mr_res got sum=%0d max=%0d idx=%0d am=%0d nm=%0b exp all 0", res_sum, res_max, res_idx, res_argmax, res_new_max); end
        accept(16'h3333, 16'h1111, 1'b0);
        wait_res(lat);
        checks++; if (lat != 11 || res_sum !== 10'd12 || res_idx !== 4'd0 || res_new_max !== 1'b1 || res_max !== 10'd12 || res_argmax !== 4'd0) begin failures++;
            $display("FAIL mr_after got lat=%0d sum=%0d idx=%0d nm=%0b max=%0d am=%0d exp 11 12 0 1 12 0", lat, res_sum, res_idx, res_new_max, res_max, res_argmax); end
        tick();
    endtask

    task automatic test_saturate();
        int lat;
        logic [3:0] exp_idx;
        accept(16'h1111, 16'h2222, 1'b1);
        wait_res(lat);
        tick();
        for (int k = 1; k <= 17; k++) begin
            exp_idx = (k > 15) ? 4'd15 : 4'(k);
            accept(16'h1111, 16'h2222, 1'b0);
            wait_res(lat);
            checks++; if (res_valid !== 1'b1 || res_idx !== exp_idx) begin failures++;
                $display("FAIL sat_idx%0d got vld=%0b idx=%0d exp 1 %0d", k, res_valid, res_idx, exp_idx); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_weights = '0; cmd_inputs = '0;
        cmd_clear_max = 1'b0; res_ready = 1'b1;
        #1;
        test_reset();
        test_load_order();
        test_basic();
        test_max_track();
        test_tie();
        test_backpressure();
        test_mid_reset();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule
